// File: rtl/data_mem_unit_pkg.sv
// Shared encodings for the data memory unit: access sizes, FSM states and
// the byte-offset width derived from XLEN.
package data_mem_unit_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Number of address bits that select a byte lane inside one XLEN word.
   function automatic int offBits(input int xlen);
      return $clog2(xlen / 8);
   endfunction

endpackage

// File: rtl/data_mem_unit_load_align.sv
// Load alignment: shifts the addressed bytes of a raw word down to bit 0 and
// sign- or zero-extends them to XLEN.
module load_align
   import data_mem_unit_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int OFF = offBits(XLEN)
) (
   input  logic [XLEN-1:0] rawWord,
   input  logic [OFF-1:0]  lane,
   input  logic [1:0]      size,
   input  logic            isUnsigned,
   output logic [XLEN-1:0] result
);

   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] keep;
   logic            signBit;

   always_comb begin
      shifted = rawWord >> {lane, 3'b000};
      keep    = '1;
      signBit = 1'b0;
      case (size)
         SIZE_B: begin
            keep    = XLEN'(8'hFF);
            signBit = shifted[7];
         end
         SIZE_H: begin
            keep    = XLEN'(16'hFFFF);
            signBit = shifted[15];
         end
         SIZE_W: begin
            keep    = XLEN'(32'hFFFF_FFFF);
            signBit = shifted[31];
         end
         default: ;
      endcase
      // Bits above the access width come from the sign bit or are cleared.
      result = (shifted & keep) | ((signBit && !isUnsigned) ? ~keep : '0);
   end

endmodule

// File: rtl/data_mem_unit.sv
// Parametrised data memory with valid/ready request and response channels,
// byte-lane stores, extended loads and a configurable response latency.
module data_mem_unit
   import data_mem_unit_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            reqValid,
   output logic            reqReady,
   input  logic            reqWrite,
   input  logic [1:0]      reqSize,
   input  logic            reqUnsigned,
   input  logic [XLEN-1:0] address,
   input  logic [XLEN-1:0] writeData,
   output logic            respValid,
   input  logic            respReady,
   output logic [XLEN-1:0] respData,
   output logic            respError
);

   localparam int OFF  = offBits(XLEN);
   localparam int NB   = XLEN / 8;
   localparam int IDXW = $clog2(DEPTH);

   logic [XLEN-1:0] mem [DEPTH];

   logic [1:0]      state;
   logic [3:0]      cnt;
   logic            accept;
   logic            misaligned;
   logic            badSize;
   logic            outOfRange;
   logic            reqErr;
   logic [IDXW-1:0] wordIdx;
   logic [OFF-1:0]  lane;
   logic [NB-1:0]   sizeMask;
   logic [NB-1:0]   wrMask;
   logic [XLEN-1:0] wrShift;
   logic [XLEN-1:0] loadData;

   assign wordIdx   = address[OFF +: IDXW];
   assign lane      = address[OFF-1:0];
   assign reqReady  = (state == ST_IDLE);
   assign respValid = (state == ST_RESP);
   assign accept    = reqValid && reqReady;

   always_comb begin
      case (reqSize)
         SIZE_B:  sizeMask = NB'(1);
         SIZE_H:  sizeMask = NB'(3);
         SIZE_W:  sizeMask = NB'(15);
         default: sizeMask = '1;
      endcase
      misaligned = ((reqSize == SIZE_H) && address[0]) ||
                   ((reqSize == SIZE_W) && (address[1:0] != 2'b00)) ||
                   ((reqSize == SIZE_D) && (address[2:0] != 3'b000));
      badSize    = (reqSize == SIZE_D) && (XLEN == 32);
      outOfRange = (address >> OFF) >= XLEN'(DEPTH);
      reqErr     = misaligned || badSize || outOfRange;
      wrMask     = sizeMask << lane;
      wrShift    = writeData << {lane, 3'b000};
   end

   load_align #(.XLEN(XLEN)) uAlign (
      .rawWord   (mem[wordIdx]),
      .lane      (lane),
      .size      (reqSize),
      .isUnsigned(reqUnsigned),
      .result    (loadData)
   );

   // Array is not reset; stores commit on the acceptance edge.
   always_ff @(posedge clk) begin
      if (accept && reqWrite && !reqErr) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (wrMask[i]) mem[wordIdx][8*i +: 8] <= wrShift[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         respData  <= '0;
         respError <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  respError <= reqErr;
                  respData  <= (reqErr || reqWrite) ? '0 : loadData;
                  if (LATENCY == 1) begin
                     state <= ST_RESP;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= 4'(LATENCY - 1);
                  end
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= ST_RESP;
            end
            ST_RESP: begin
               if (respReady) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: 32-bit latency-1, 32-bit latency-4 and
// 64-bit latency-1 instances sharing one clock and request bus.
module tb_data_mem_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  reqValid = '0;
   logic [2:0]  reqReady;
   logic [2:0]  respValid;
   logic [2:0]  respReady = '1;
   logic [2:0]  respError;
   logic        reqWrite = 1'b0;
   logic [1:0]  reqSize = 2'b00;
   logic        reqUnsigned = 1'b0;
   logic [63:0] addr = '0;
   logic [63:0] wdata = '0;
   logic [31:0] rd0, rd1;
   logic [63:0] rd2;

   int pass = 0;
   int total = 0;

   always #5 clk = ~clk;

   data_mem_unit #(.XLEN(32), .DEPTH(64), .LATENCY(1)) dut0 (
      .clk(clk), .reset(rst), .reqValid(reqValid[0]), .reqReady(reqReady[0]),
      .reqWrite(reqWrite), .reqSize(reqSize), .reqUnsigned(reqUnsigned),
      .address(addr[31:0]), .writeData(wdata[31:0]), .respValid(respValid[0]),
      .respReady(respReady[0]), .respData(rd0), .respError(respError[0]));

   data_mem_unit #(.XLEN(32), .DEPTH(64), .LATENCY(4)) dut1 (
      .clk(clk), .reset(rst), .reqValid(reqValid[1]), .reqReady(reqReady[1]),
      .reqWrite(reqWrite), .reqSize(reqSize), .reqUnsigned(reqUnsigned),
      .address(addr[31:0]), .writeData(wdata[31:0]), .respValid(respValid[1]),
      .respReady(respReady[1]), .respData(rd1), .respError(respError[1]));

   data_mem_unit #(.XLEN(64), .DEPTH(64), .LATENCY(1)) dut2 (
      .clk(clk), .reset(rst), .reqValid(reqValid[2]), .reqReady(reqReady[2]),
      .reqWrite(reqWrite), .reqSize(reqSize), .reqUnsigned(reqUnsigned),
      .address(addr), .writeData(wdata), .respValid(respValid[2]),
      .respReady(respReady[2]), .respData(rd2), .respError(respError[2]));

   function automatic logic [63:0] rdata(input int d);
      case (d)
         0:       return {32'h0, rd0};
         1:       return {32'h0, rd1};
         default: return rd2;
      endcase
   endfunction

   // Issues one request and returns when respValid is seen; completes the
   // handshake only if respReady is high for that instance.
   task automatic txn(input int d, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [63:0] a, input logic [63:0] wd,
                      output logic [63:0] data, output logic err, output int lat,
                      output logic sawRdy);
      int n = 0;
      data = '0; err = 1'b0; lat = 0; sawRdy = 1'b0;
      @(negedge clk);
      reqWrite = wr; reqSize = sz; reqUnsigned = uns; addr = a; wdata = wd;
      reqValid[d] = 1'b1;
      while (!reqReady[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!reqReady[d]) begin
         total++;
         $display("FAIL accept_timeout dut%0d: reqReady=%b required 1", d, reqReady[d]);
         reqValid[d] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      reqValid[d] = 1'b0;
      lat = 1;
      sawRdy = reqReady[d];
      while (!respValid[d] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         sawRdy |= reqReady[d];
      end
      if (!respValid[d]) begin
         total++;
         $display("FAIL resp_timeout dut%0d: respValid=%b required 1", d, respValid[d]);
         return;
      end
      data = rdata(d);
      err  = respError[d];
      if (respReady[d]) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      #3;
      total++; if (reqReady !== 3'b111) $display("FAIL rst_reqReady: got %b required 111", reqReady); else pass++;
      total++; if (respValid !== 3'b000) $display("FAIL rst_respValid: got %b required 000", respValid); else pass++;
      total++; if (respError !== 3'b000) $display("FAIL rst_respError: got %b required 000", respError); else pass++;
      total++; if (rd0 !== 32'h0) $display("FAIL rst_respData0: got %h required 0", rd0); else pass++;
      total++; if (rd2 !== 64'h0) $display("FAIL rst_respData2: got %h required 0", rd2); else pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_store_load();
      logic [63:0] d; logic e; int l; logic s;
      txn(0, 1'b1, 2'b10, 1'b0, 64'h10, 64'hDEADBEEF, d, e, l, s);
      total++; if (e !== 1'b0) $display("FAIL sw_err: got %b required 0", e); else pass++;
      total++; if (d !== 64'h0) $display("FAIL sw_data: got %h required 0", d); else pass++;
      txn(0, 1'b0, 2'b10, 1'b0, 64'h10, 64'h0, d, e, l, s);
      total++; if (l != 1) $display("FAIL lw_latency: got %0d required 1", l); else pass++;
      total++; if (d !== 64'hDEADBEEF) $display("FAIL lw_data: got %h required deadbeef", d); else pass++;
      total++; if (e !== 1'b0) $display("FAIL lw_err: got %b required 0", e); else pass++;
   endtask

   task automatic test_extend();
      logic [63:0] d; logic e; int l; logic s;
      txn(0, 1'b0, 2'b00, 1'b0, 64'h13, 64'h0, d, e, l, s);
      total++; if (d !== 64'hFFFFFFDE) $display("FAIL lb: got %h required ffffffde", d); else pass++;
      txn(0, 1'b0, 2'b00, 1'b1, 64'h13, 64'h0, d, e, l, s);
      total++; if (d !== 64'h000000DE) $display("FAIL lbu: got %h required 000000de", d); else pass++;
      txn(0, 1'b0, 2'b01, 1'b0, 64'h12, 64'h0, d, e, l, s);
      total++; if (d !== 64'hFFFFDEAD) $display("FAIL lh: got %h required ffffdead", d); else pass++;
      txn(0, 1'b0, 2'b01, 1'b1, 64'h10, 64'h0, d, e, l, s);
      total++; if (d !== 64'h0000BEEF) $display("FAIL lhu: got %h required 0000beef", d); else pass++;
      txn(0, 1'b1, 2'b00, 1'b0, 64'h11, 64'h55, d, e, l, s);
      txn(0, 1'b0, 2'b10, 1'b0, 64'h10, 64'h0, d, e, l, s);
      total++; if (d !== 64'hDEAD55EF) $display("FAIL sb_lw: got %h required dead55ef", d); else pass++;
   endtask

   task automatic test_errors();
      logic [63:0] d; logic e; int l; logic s;
      txn(0, 1'b1, 2'b10, 1'b0, 64'h0, 64'h12345678, d, e, l, s);
      txn(0, 1'b0, 2'b01, 1'b0, 64'h1, 64'h0, d, e, l, s);
      total++; if ({e, d} !== {1'b1, 64'h0}) $display("FAIL lh_misalign: got err=%b data=%h required err=1 data=0", e, d); else pass++;
      txn(0, 1'b0, 2'b10, 1'b0, 64'h2, 64'h0, d, e, l, s);
      total++; if ({e, d} !== {1'b1, 64'h0}) $display("FAIL lw_misalign: got err=%b data=%h required err=1 data=0", e, d); else pass++;
      txn(0, 1'b0, 2'b10, 1'b0, 64'd256, 64'h0, d, e, l, s);
      total++; if ({e, d} !== {1'b1, 64'h0}) $display("FAIL lw_range: got err=%b data=%h required err=1 data=0", e, d); else pass++;
      txn(0, 1'b0, 2'b11, 1'b0, 64'h0, 64'h0, d, e, l, s);
      total++; if ({e, d} !== {1'b1, 64'h0}) $display("FAIL ld_on32: got err=%b data=%h required err=1 data=0", e, d); else pass++;
      txn(0, 1'b1, 2'b10, 1'b0, 64'h2, 64'hFFFFFFFF, d, e, l, s);
      total++; if (e !== 1'b1) $display("FAIL sw_misalign: got err=%b required 1", e); else pass++;
      txn(0, 1'b0, 2'b10, 1'b0, 64'h0, 64'h0, d, e, l, s);
      total++; if (d !== 64'h12345678) $display("FAIL mem_unchanged: got %h required 12345678", d); else pass++;
      txn(0, 1'b1, 2'b10, 1'b0, 64'd252, 64'hA5A50F0F, d, e, l, s);
      txn(0, 1'b0, 2'b10, 1'b0, 64'd252, 64'h0, d, e, l, s);
      total++; if ({e, d} !== {1'b0, 64'hA5A50F0F}) $display("FAIL last_word: got err=%b data=%h required err=0 data=a5a50f0f", e, d); else pass++;
   endtask

   task automatic test_stall();
      logic [63:0] d; logic e; int l; logic s;
      logic bad = 1'b0;
      txn(1, 1'b1, 2'b10, 1'b0, 64'h10, 64'h600DCAFE, d, e, l, s);
      total++; if (l != 4) $display("FAIL sw_lat4: got %0d required 4", l); else pass++;
      respReady[1] = 1'b0;
      txn(1, 1'b0, 2'b10, 1'b0, 64'h10, 64'h0, d, e, l, s);
      total++; if (l != 4) $display("FAIL lw_lat4: got %0d required 4", l); else pass++;
      total++; if (s !== 1'b0) $display("FAIL wait_reqReady: got %b required 0", s); else pass++;
      total++; if (d !== 64'h600DCAFE) $display("FAIL lat4_data: got %h required 600dcafe", d); else pass++;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (!respValid[1] || reqReady[1] || rd1 !== 32'h600DCAFE) bad = 1'b1;
      end
      total++; if (bad !== 1'b0) $display("FAIL stall_stable: got unstable=%b required 0", bad); else pass++;
      respReady[1] = 1'b1;
      @(posedge clk); #1;
      total++; if ({respValid[1], reqReady[1]} !== 2'b01) $display("FAIL stall_done: got valid,ready=%b required 01", {respValid[1], reqReady[1]}); else pass++;
   endtask

   task automatic test_reset_mid();
      logic [63:0] d; logic e; int l; logic s;
      @(negedge clk);
      reqWrite = 1'b1; reqSize = 2'b10; reqUnsigned = 1'b0; addr = 64'h20; wdata = 64'hCAFEF00D;
      reqValid[1] = 1'b1;
      @(posedge clk); #1;
      reqValid[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      total++; if ({respValid[1], reqReady[1]} !== 2'b01) $display("FAIL rst_mid_sw: got valid,ready=%b required 01", {respValid[1], reqReady[1]}); else pass++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      reqWrite = 1'b0; addr = 64'h10;
      reqValid[1] = 1'b1;
      @(posedge clk); #1;
      reqValid[1] = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      #1;
      total++; if ({respValid[1], reqReady[1]} !== 2'b01) $display("FAIL rst_mid_lw: got valid,ready=%b required 01", {respValid[1], reqReady[1]}); else pass++;
      @(negedge clk);
      rst = 1'b0;
      txn(1, 1'b0, 2'b10, 1'b0, 64'h20, 64'h0, d, e, l, s);
      total++; if (d !== 64'hCAFEF00D) $display("FAIL store_kept: got %h required cafef00d", d); else pass++;
      txn(1, 1'b0, 2'b10, 1'b0, 64'h10, 64'h0, d, e, l, s);
      total++; if (d !== 64'h600DCAFE) $display("FAIL word_kept: got %h required 600dcafe", d); else pass++;
   endtask

   task automatic test_xlen64();
      logic [63:0] d; logic e; int l; logic s;
      txn(2, 1'b1, 2'b11, 1'b0, 64'h8, 64'h0123456789ABCDEF, d, e, l, s);
      total++; if ({e, d} !== {1'b0, 64'h0}) $display("FAIL sd: got err=%b data=%h required err=0 data=0", e, d); else pass++;
      txn(2, 1'b0, 2'b10, 1'b0, 64'hC, 64'h0, d, e, l, s);
      total++; if (d !== 64'h0000000001234567) $display("FAIL lw64_hi: got %h required 0000000001234567", d); else pass++;
      txn(2, 1'b0, 2'b10, 1'b0, 64'h8, 64'h0, d, e, l, s);
      total++; if (d !== 64'hFFFFFFFF89ABCDEF) $display("FAIL lw64_lo: got %h required ffffffff89abcdef", d); else pass++;
      txn(2, 1'b0, 2'b11, 1'b0, 64'h4, 64'h0, d, e, l, s);
      total++; if ({e, d} !== {1'b1, 64'h0}) $display("FAIL ld_misalign: got err=%b data=%h required err=1 data=0", e, d); else pass++;
      txn(2, 1'b0, 2'b11, 1'b0, 64'h8, 64'h0, d, e, l, s);
      total++; if (d !== 64'h0123456789ABCDEF) $display("FAIL ld: got %h required 0123456789abcdef", d); else pass++;
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_extend();
      test_errors();
      test_stall();
      test_reset_mid();
      test_xlen64();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Parametrised successor to the single-cycle data memory: XLEN-wide, DEPTH-word array with byte/half/word(/double) access, sign/zero extension and little-endian byte lanes.
- Uses a valid/ready request channel and a valid/ready response channel, with a configurable read/ack latency, so later multi-cycle cores can stall on memory.
- Sits between the core's load/store unit and the data array.

Parameters:
- XLEN, 32: data/address width; must be 32 or 64.
- DEPTH, 1024: number of XLEN-bit words.
- LATENCY, 1: cycles from request acceptance to respValid; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqValid  in  1  request present.
- reqReady  out  1  unit can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only).
- reqUnsigned  in  1  load zero-extends when 1.
- address  in  XLEN  byte address.
- writeData  in  XLEN  store data in the low bits.
- respValid  out  1  response present.
- respReady  in  1  consumer accepts the response.
- respData  out  XLEN  extended load data; 0 for stores and errors.
- respError  out  1  misaligned, out of range, or illegal size.

Behaviour:
- Reset is asynchronous and active-high. Reset values: state IDLE, reqReady=1, respValid=0, respData=0, respError=0, latency counter 0. The memory array is not cleared.
- Definitions: OFF = log2(XLEN/8) offset bits; word index = address[OFF +: log2(DEPTH)]; lane = address[OFF-1:0].
- Acceptance: a request is accepted on the edge where reqValid && reqReady. Address, size and control are latched at that edge.
- Error if any of the following hold; on error there is no array update, respError=1 and respData=0:
  - half access with address[0] != 0;
  - word access with address[1:0] != 0;
  - double access with address[2:0] != 0;
  - reqSize=11 while XLEN=32;
  - address >> OFF >= DEPTH.
- Store: commits on the acceptance edge.
  - Only the addressed byte lanes are written: 1, 2, 4 or 8 lanes starting at the lane offset.
  - Source is writeData low bits; other lanes are untouched.
- Load: the word is read at the acceptance edge. The addressed bytes are extracted, then sign-extended (reqUnsigned=0) or zero-extended into respData.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: reqReady=1. On acceptance, go to RESP if LATENCY=1, else to WAIT with counter=LATENCY-1.
  - WAIT: reqReady=0. Decrement the counter each cycle; go to RESP when the counter reaches 1.
  - RESP: respValid=1; respData and respError are held stable; reqReady=0. On respValid && respReady, go to IDLE and clear respValid.
- Latency: respValid is first high exactly LATENCY edges after the acceptance edge.
- Throughput: with respReady tied high, one request every LATENCY+1 cycles. A new request cannot be accepted in the same cycle a response completes.
- Boundaries:
  - Back-to-back store then load to the same address: the load returns the new data.
  - respReady held low keeps RESP indefinitely with outputs stable.
  - reqValid while reqReady=0 is ignored; the requester must hold it.
  - Reset asserted mid-WAIT or mid-RESP drops the pending response immediately. A store already accepted remains committed.
  - Last word (index DEPTH-1) is legal; index DEPTH is an error.

Decomposition:
- Parameters.vh gains: SIZE_B/SIZE_H/SIZE_W/SIZE_D encodings, FSM state encodings (2-bit), and an OFF derivation macro/localparam.
- One combinational sub-module, load_align:
  - inputs: raw word, lane, size, unsigned flag;
  - output: extended XLEN result.
  - The top keeps the FSM, counter, array and lane-write logic.

Test Plan:
1. Reset then SW 0xDEADBEEF @0x10, LW @0x10, LATENCY=1, respReady=1 -> store resp respError=0, respData=0; load respValid one edge after acceptance, respData=0xDEADBEEF.
2. After scenario 1: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; SB 0x55 @0x11 then LW @0x10 -> 0xDEAD55EF.
3. LH @0x01, LW @0x02, and LW @ 4*DEPTH -> each respError=1, respData=0, memory unchanged (LW @0x00 afterwards returns its prior value).
4. LATENCY=4, respReady=0 for 3 cycles after respValid -> respValid high 4 edges after acceptance, reqReady=0 throughout, respData stable, completes on the first respReady=1 edge.
5. Assert reset during WAIT of a LW (LATENCY=4) -> respValid=0 and reqReady=1 immediately; the previously stored word is still readable after reset.
6. XLEN=64 build: SD 0x0123456789ABCDEF @0x8, LW @0xC -> 0x0000000001234567; LD @0x4 -> respError=1.
